core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the ProtoCore datapath.
- Fetches 24-bit instructions from instruction memory over a req/valid handshake and holds each one in an instruction register (IR) that feeds the instruction decoder.
- Sequences execute and register-file writeback for every instruction.
- Maintains the PC, handles HALT, and exposes a retired-instruction counter and state for debug.

Parameters:
- PC_WIDTH, 8, width of PC and imem_addr.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level enable; sampled only at instruction boundaries.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_WIDTH  fetch address; always equals pc.
- imem_rdata  input  24  fetched instruction word.
- imem_valid  input  1  imem_rdata valid this cycle; ignored unless imem_req=1.
- ir  output  24  instruction register; drives decoder instruction input.
- dec_alu_en  input  1  decoder alu_en for the current ir.
- dec_write_en  input  1  decoder write_en for the current ir.
- dec_halt  input  1  decoder HALT for the current ir.
- exec_en  output  1  one-cycle ALU execute/operand-capture strobe.
- rf_we  output  1  register-file write strobe; gated copy of dec_write_en.
- pc  output  PC_WIDTH  program counter.
- halted  output  1  core stopped on HALT.
- state  output  3  current FSM state encoding (debug).
- retired  output  COUNT_WIDTH  count of completed non-HALT instructions.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- rst=1 at an edge forces:
  - state=IDLE, pc=0, ir=0, retired=0.
  - All strobes low (imem_req, exec_en, rf_we, halted).
  - Reset overrides every state, including mid-fetch and HALTED. Any in-flight fetch is abandoned; an imem_valid arriving after reset is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs are Moore decodes of the state register:
  - imem_req=1 only in FETCH.
  - exec_en=1 only in EXECUTE.
  - rf_we = dec_write_en only in WRITEBACK, 0 elsewhere.
  - halted=1 only in HALTED.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - Hold imem_req=1 with imem_addr=pc until imem_valid=1.
  - On that edge: ir <= imem_rdata, go to DECODE.
  - Wait states are unbounded. run is not sampled here; a started fetch always completes.
- DECODE: one cycle; the decoder is combinational on ir. Priority:
  - dec_halt=1 -> HALTED. pc and retired unchanged.
  - Else dec_alu_en=1 -> EXECUTE.
  - Else (reserved memory/branch opcodes 0xA-0xE): treated as NOP. pc <= pc+1, retired <= retired+1, next state FETCH if run=1 else IDLE.
- EXECUTE: one cycle, exec_en=1, -> WRITEBACK.
- WRITEBACK:
  - rf_we follows dec_write_en.
  - pc <= pc+1, retired <= retired+1.
  - Next state FETCH if run=1, else IDLE.
- HALTED: sticky; leaves only on rst. run is ignored.
- ir is held stable from DECODE through WRITEBACK, so decoder outputs are stable for the whole instruction.
- pc wraps modulo 2^PC_WIDTH (max -> 0).
- retired saturates at all-ones and does not wrap.
- Latency with zero imem wait states:
  - ALU instruction: 4 cycles, FETCH->DECODE->EXECUTE->WRITEBACK, then back-to-back FETCH.
  - NOP: 2 cycles.
  - Each cycle of imem_valid=0 adds 1 cycle.
- At most one rf_we pulse per instruction. Never rf_we and exec_en in the same cycle.

Test Plan:
- Reset values: hold rst 2 cycles with run=1 and imem_valid=1 -> state=0, pc=0, ir=0, retired=0, all strobes 0; first imem_req appears the cycle after rst drops.
- Back-to-back ALU instructions:
  - Stimulus: imem returns 0x012300 (ADD r1,r2->r3) at pc=0 and 0x845A07 at pc=1; imem_valid=1 every cycle; decoder model connected.
  - Required: imem_req, exec_en, rf_we each pulse on cycles 0, 2, 3 and again on 4, 6, 7; pc=2, retired=2 after cycle 7.
- Wait states: imem_valid delayed 3 cycles at pc=5 -> imem_req high for 4 cycles, imem_addr=5 throughout, ir captured only on the valid cycle, instruction total 7 cycles.
- NOP and HALT:
  - Stimulus: 0xA00000 at pc=0, 0xF00000 at pc=1.
  - Required: 0xA00000 gives no exec_en and no rf_we, pc=1, retired=1; 0xF00000 gives halted=1 with pc=1, retired=1 held for 20 cycles with run=1; rst clears it.
- Boundaries:
  - pc=255 completing an ALU op -> pc=0.
  - retired preloaded near max (via a long run) stops at 0xFFFF.
  - run dropped during FETCH -> instruction completes, then IDLE with imem_req=0.
- Reset mid-instruction: assert rst during EXECUTE -> next cycle state=IDLE, rf_we never pulses, pc=0, retired=0.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer and imem.
//   imem_req   : fetch request (sequencer -> imem)
//   imem_addr  : fetch address (sequencer -> imem)
//   imem_rdata : 24-bit instruction word (imem -> sequencer)
//   imem_valid : rdata valid this cycle; only meaningful while imem_req=1
// master = sequencer side, slave = memory side.
interface core_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [23:0]         imem_rdata;
    logic                imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the ProtoCore datapath.
// Fetches an instruction into ir, lets the external decoder look at it, then
// runs EXECUTE/WRITEBACK for ALU ops, retires reserved opcodes as NOPs, and
// parks in HALTED on HALT until reset.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   run           : level enable, looked at only on instruction boundaries
//   imem          : fetch channel (master side), imem_addr always equals pc
//   ir            : instruction register feeding the decoder
//   dec_*         : decoder outputs for the current ir
//   exec_en       : one-cycle ALU execute strobe
//   rf_we         : register-file write strobe (WRITEBACK only)
//   pc, halted    : program counter, sticky halt flag
//   state         : FSM state for debug
//   retired       : saturating count of completed non-HALT instructions
module core_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    core_sequencer_if.master       imem,
    output logic [23:0]            ir,
    input  logic                   dec_alu_en,
    input  logic                   dec_write_en,
    input  logic                   dec_halt,
    output logic                   exec_en,
    output logic                   rf_we,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam logic [PC_WIDTH-1:0]    PC_ONE  = 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    state_t state_q;
    state_t state_d;
    logic   retire;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; codes 6/7 fall into the default and recover to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = imem.imem_valid ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (dec_halt)        state_d = S_HALTED;
                else if (dec_alu_en) state_d = S_EXECUTE;
                else                 state_d = run ? S_FETCH : S_IDLE;
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
            S_HALTED:    state_d = S_HALTED;
            default:     state_d = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        imem.imem_req = (state_q == S_FETCH);
        exec_en       = (state_q == S_EXECUTE);
        rf_we         = (state_q == S_WRITEBACK) && dec_write_en;
        halted        = (state_q == S_HALTED);
    end

    // An instruction retires either at WRITEBACK or straight out of DECODE
    // when it is a reserved opcode (neither HALT nor ALU).
    assign retire = (state_q == S_WRITEBACK) ||
                    ((state_q == S_DECODE) && !dec_halt && !dec_alu_en);

    // ir only loads on the accepting fetch edge, so it stays put from
    // DECODE through WRITEBACK and the decoder outputs stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
        end else begin
            if (state_q == S_FETCH && imem.imem_valid)
                ir <= imem.imem_rdata;
            if (retire) begin
                pc <= pc + PC_ONE;                 // wraps naturally
                if (retired != '1)
                    retired <= retired + CNT_ONE;  // saturate, never wrap
            end
        end
    end

    assign imem.imem_addr = pc;
    assign state          = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer. The counter width is shrunk to 8 bits so that
// saturation is reachable in a short run. Each instruction is checked as a
// whole against a per-instruction model: cycle count, strobe counts, final
// pc/retired/ir/state derived from the opcode and the wait states.
module tb_core_sequencer;
    localparam int PCW = 8;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run = 1'b0;
    logic [23:0]    ir;
    logic           dec_alu_en, dec_write_en, dec_halt;
    logic           exec_en, rf_we, halted;
    logic [PCW-1:0] pc;
    logic [2:0]     state;
    logic [CW-1:0]  retired;

    logic [23:0] mem [256];
    int          wait_tab [256];
    int          wcnt;
    logic        force_valid = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int exp_pc, exp_ret;

    core_sequencer_if #(.PC_WIDTH(PCW)) imem_bus ();

    core_sequencer #(.PC_WIDTH(PCW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .imem(imem_bus.master), .ir(ir),
        .dec_alu_en(dec_alu_en), .dec_write_en(dec_write_en), .dec_halt(dec_halt),
        .exec_en(exec_en), .rf_we(rf_we), .pc(pc), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Decoder: opcode F = HALT, 0-9 = ALU, A-E = reserved; bit 19 set = no write
    assign dec_halt     = (ir[23:20] == 4'hF);
    assign dec_alu_en   = (ir[23:20] <= 4'h9);
    assign dec_write_en = !ir[19];

    // Memory: answers after wait_tab[addr] cycles of continuous request
    assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];
    assign imem_bus.imem_valid = force_valid |
        (imem_bus.imem_req && (wcnt >= wait_tab[imem_bus.imem_addr]));

    always @(posedge clk) begin
        if (rst || !imem_bus.imem_req || imem_bus.imem_valid) wcnt <= 0;
        else                                                   wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc  = 0;
        exp_ret = 0;
    endtask

    task automatic go_fetch();
        run = 1'b1;
        for (int i = 0; i < 10 && state != 3'd1; i++) @(negedge clk);
        chk("reach_fetch", 32'(state), 32'd1);
    endtask

    // Called at a negedge while in FETCH; follows one instruction to its end.
    task automatic run_instr(input bit drop_run);
        logic [23:0] w, ir0;
        bit   is_halt, is_alu, is_we, left;
        int   waits, cyc, nreq, nexec, nwe, both, addr_bad, ir_bad, exp_cyc, exp_end;
        w       = mem[exp_pc];
        waits   = wait_tab[exp_pc];
        is_halt = (w[23:20] == 4'hF);
        is_alu  = (w[23:20] <= 4'h9);
        is_we   = is_alu && !w[19];
        ir0 = ir; left = 0;
        cyc = 0; nreq = 0; nexec = 0; nwe = 0; both = 0; addr_bad = 0; ir_bad = 0;
        if (drop_run) run = 1'b0;
        while (1) begin
            if (imem_bus.imem_req) begin
                nreq++;
                if (imem_bus.imem_addr !== PCW'(exp_pc)) addr_bad++;
            end
            if (state == 3'd1 && ir !== ir0) ir_bad++;
            if (exec_en) nexec++;
            if (rf_we) nwe++;
            if (exec_en && rf_we) both++;
            @(negedge clk);
            cyc++;
            if (state != 3'd1) left = 1;
            if ((left && (state == 3'd0 || state == 3'd1 || state == 3'd5)) || cyc >= 60) break;
        end
        exp_cyc = waits + ((is_alu && !is_halt) ? 4 : 2);
        exp_end = is_halt ? 5 : (drop_run ? 0 : 1);
        if (!is_halt) begin
            exp_pc  = (exp_pc + 1) % 256;
            exp_ret = (exp_ret < CNT_MAX) ? exp_ret + 1 : CNT_MAX;
        end
        chk("cycles",      32'(cyc),      32'(exp_cyc));
        chk("req_cycles",  32'(nreq),     32'(waits + 1));
        chk("exec_pulses", 32'(nexec),    32'(is_alu && !is_halt));
        chk("rfwe_pulses", 32'(nwe),      32'(is_we && !is_halt));
        chk("exec_and_we", 32'(both),     32'd0);
        chk("addr_eq_pc",  32'(addr_bad), 32'd0);
        chk("ir_hold",     32'(ir_bad),   32'd0);
        chk("ir_capture",  32'(ir),       32'(w));
        chk("pc",          32'(pc),       32'(exp_pc));
        chk("retired",     32'(retired),  32'(exp_ret));
        chk("end_state",   32'(state),    32'(exp_end));
        chk("halted",      32'(halted),   32'(is_halt));
    endtask

    initial begin
        int bad, nwe;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 24'hA00000;
            wait_tab[i] = 0;
        end
        exp_pc = 0; exp_ret = 0;

        // Reset with run and valid forced high
        mem[0] = 24'h012300;
        mem[1] = 24'h845A07;
        rst = 1'b1; run = 1'b1; force_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_pc",      32'(pc),      32'd0);
        chk("rst_ir",      32'(ir),      32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_strobes", 32'({imem_bus.imem_req, exec_en, rf_we, halted}), 32'd0);
        rst = 1'b0; force_valid = 1'b0;
        chk("req_low_idle", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_bus.imem_req), 32'd1);

        // Back-to-back ALU instructions
        run_instr(0);
        run_instr(0);
        chk("b2b_pc", 32'(pc), 32'd2);

        // Wait states at pc=5
        do_reset();
        mem[0] = 24'hA00000; mem[1] = 24'hA00000;
        mem[5] = 24'h012300;
        wait_tab[5] = 3;
        go_fetch();
        for (int i = 0; i < 6; i++) run_instr(0);
        wait_tab[5] = 0;

        // NOP then HALT, HALT sticky with run=1, reset clears
        do_reset();
        mem[0] = 24'hA00000;
        mem[1] = 24'hF00000;
        go_fetch();
        run_instr(0);
        run_instr(0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (halted !== 1'b1 || pc !== 8'd1 || retired !== 8'd1) bad++;
        end
        chk("halt_sticky", 32'(bad), 32'd0);
        do_reset();
        chk("halt_cleared", 32'({halted, state}), 32'd0);

        // pc wrap at 255 and retired saturation
        for (int i = 0; i < 256; i++) mem[i] = 24'hA00000;
        mem[255] = 24'h012300;
        go_fetch();
        for (int i = 0; i < 256; i++) run_instr(0);
        chk("pc_wrap",   32'(pc),      32'd0);
        chk("ret_sat",   32'(retired), 32'(CNT_MAX));
        for (int i = 0; i < 3; i++) run_instr(0);
        chk("ret_stuck", 32'(retired), 32'(CNT_MAX));

        // run dropped during FETCH
        do_reset();
        mem[0] = 24'h012300;
        wait_tab[0] = 2;
        go_fetch();
        run_instr(1);
        repeat (3) @(negedge clk);
        chk("drop_idle", 32'({state, imem_bus.imem_req}), 32'd0);
        wait_tab[0] = 0;

        // Reset during EXECUTE
        do_reset();
        mem[0] = 24'h012300;
        go_fetch();
        for (int i = 0; i < 20 && state != 3'd3; i++) @(negedge clk);
        chk("in_execute", 32'(state), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state", 32'(state),   32'd0);
        chk("mid_rst_pc",    32'(pc),      32'd0);
        chk("mid_rst_ret",   32'(retired), 32'd0);
        nwe = 0;
        repeat (3) begin
            if (rf_we) nwe++;
            @(negedge clk);
        end
        chk("mid_rst_no_we", 32'(nwe), 32'd0);
        exp_pc = 0; exp_ret = 0;

        // Randomized program, random waits and run drops
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 24'($urandom());
            wait_tab[i] = $urandom_range(0, 3);
        end
        do_reset();
        for (int n = 0; n < 200; n++) begin
            if (state == 3'd5) begin
                repeat (3) @(negedge clk);
                chk("rand_halt", 32'({halted, pc}), 32'({1'b1, 8'(exp_pc)}));
                do_reset();
            end
            go_fetch();
            run_instr($urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
